// File: rtl/sseg_scan_driver.sv
// Time-multiplexed hex seven-segment driver, common-anode, double-buffered at frame boundaries.
// Optional SSEG_LEADING_ZERO_BLANK_EN: auto-blank leading zero digits (digit 0 never blanked).
module sseg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    load_in,
   output logic [7:0]              sseg_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    pending_out,
   output logic                    frame_out
);

   localparam int PW = $clog2(CLK_DIV);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PSC_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] BLANK_P  = PW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [PW-1:0]           psc_q, psc_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
   logic [NUM_DIGITS-1:0]   act_blk_q, act_blk_d, pend_blk_q, pend_blk_d;
   logic                    pending_q, pending_d;
   logic [7:0]              sseg_q, sseg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;

   logic                    term_cnt, frame;
   logic [NUM_DIGITS-1:0]   lz_blk;
   logic                    upper_zero;
   logic [3:0]              nib;

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'h40;
         4'h1: seg7 = 7'h79;
         4'h2: seg7 = 7'h24;
         4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;
         4'h5: seg7 = 7'h12;
         4'h6: seg7 = 7'h02;
         4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;
         4'h9: seg7 = 7'h10;
         4'hA: seg7 = 7'h08;
         4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;
         4'hD: seg7 = 7'h21;
         4'hE: seg7 = 7'h06;
         default: seg7 = 7'h0E;
      endcase
   endfunction

   always_comb begin
      term_cnt = (psc_q == PSC_LAST);
      frame    = term_cnt && (idx_q == IDX_LAST);

      psc_d = term_cnt ? '0 : psc_q + 1'b1;
      idx_d = idx_q;
      if (term_cnt)
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

      act_val_d  = act_val_q;
      act_dp_d   = act_dp_q;
      act_blk_d  = act_blk_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      pend_blk_d = pend_blk_q;
      pending_d  = pending_q;

      // A load landing on the boundary itself goes straight to the active set.
      if (frame) begin
         if (load_in) begin
            act_val_d = value_in;
            act_dp_d  = dp_in;
            act_blk_d = blank_in;
         end else if (pending_q) begin
            act_val_d = pend_val_q;
            act_dp_d  = pend_dp_q;
            act_blk_d = pend_blk_q;
         end
         pending_d = 1'b0;
      end else if (load_in) begin
         pend_val_d = value_in;
         pend_dp_d  = dp_in;
         pend_blk_d = blank_in;
         pending_d  = 1'b1;
      end
   end

   always_comb begin
      lz_blk     = '0;
      upper_zero = 1'b1;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         upper_zero = upper_zero && (act_val_q[4*k +: 4] == 4'h0);
         lz_blk[k]  = upper_zero && !act_dp_q[k];
      end
`endif

      nib = act_val_q[4*int'(idx_q) +: 4];
      if (act_blk_q[idx_q] || lz_blk[idx_q])
         sseg_d = 8'hFF;
      else
         sseg_d = {~act_dp_q[idx_q], seg7(nib)};

      an_d = '1;
      if (psc_q >= BLANK_P)
         an_d[idx_q] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         psc_q      <= '0;
         idx_q      <= '0;
         act_val_q  <= '0;
         act_dp_q   <= '0;
         act_blk_q  <= '0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         pend_blk_q <= '0;
         pending_q  <= 1'b0;
         sseg_q     <= 8'hFF;
         an_q       <= '1;
      end else begin
         psc_q      <= psc_d;
         idx_q      <= idx_d;
         act_val_q  <= act_val_d;
         act_dp_q   <= act_dp_d;
         act_blk_q  <= act_blk_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         pend_blk_q <= pend_blk_d;
         pending_q  <= pending_d;
         sseg_q     <= sseg_d;
         an_q       <= an_d;
      end
   end

   assign sseg_out    = sseg_q;
   assign an_out      = an_q;
   assign pending_out = pending_q;
   assign frame_out   = frame;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver: 4 digits, CLK_DIV=8, BLANK_CYCLES=2.
module tb_sseg_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic        load_in;
   logic [7:0]  sseg_out;
   logic [3:0]  an_out;
   logic        pending_out;
   logic        frame_out;

   int checks   = 0;
   int failures = 0;
   int cnt;

`ifdef SSEG_LEADING_ZERO_BLANK_EN
   localparam logic [7:0] Z = 8'hFF;
`else
   localparam logic [7:0] Z = 8'hC0;
`endif

   sseg_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .value_in(value_in), .dp_in(dp_in),
      .blank_in(blank_in), .load_in(load_in), .sseg_out(sseg_out),
      .an_out(an_out), .pending_out(pending_out), .frame_out(frame_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
      value_in = v;
      dp_in    = dp;
      blank_in = bl;
      load_in  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load_in  = 1'b0;
   endtask

   // Returns the number of edges until frame_out is seen high; 200 bounds the wait.
   task automatic wait_frame(output int n);
      n = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end while (!frame_out && n < 200);
      if (n >= 200) chk("frame_timeout", 32'd0, 32'd1);
   endtask

   // Entered at the negedge where frame_out is high; walks one full frame and
   // ends on the next frame_out negedge. Edge i=2 shows slot 0, prescaler 0.
   task automatic scan_frame(input int start, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] e [4];
      logic [3:0] exp_an;
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int i = start; i <= 32; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("frame_out", 32'(frame_out), 32'(i == 32));
         if (i == 1) begin
            chk("an_last_slot", 32'(an_out), 32'h7);
         end else begin
            exp_an = ((i - 2) % 8 < 2) ? 4'hF : ~(4'b0001 << ((i - 2) / 8));
            chk("an_scan", 32'(an_out), 32'(exp_an));
            chk("sseg_scan", 32'(sseg_out), 32'(e[(i - 2) / 8]));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; value_in = '0; dp_in = '0; blank_in = '0; load_in = 1'b0;
      @(negedge clk);
      chk("rst_sseg", 32'(sseg_out), 32'hFF);
      chk("rst_an", 32'(an_out), 32'hF);
      chk("rst_pending", 32'(pending_out), 32'h0);
      chk("rst_frame", 32'(frame_out), 32'h0);
      rst_n = 1'b1;

      // Idle scan of zeros; first boundary 31 edges after release.
      wait_frame(cnt);
      chk("first_frame_edges", 32'(cnt), 32'd31);
      scan_frame(1, 8'hC0, Z, Z, Z);

      // Single load with dp on digit 2.
      step(3);
      load(16'h12AF, 4'b0100, 4'b0000);
      chk("pending_set", 32'(pending_out), 32'h1);
      wait_frame(cnt);
      chk("pending_held", 32'(pending_out), 32'h1);
      scan_frame(1, 8'h8E, 8'h88, 8'h24, 8'hF9);
      chk("pending_clr", 32'(pending_out), 32'h0);

      // Two loads in one frame: last one wins.
      step(3);
      load(16'h1111, 4'b0000, 4'b0000);
      step(2);
      load(16'h2222, 4'b0000, 4'b0000);
      wait_frame(cnt);
      scan_frame(1, 8'hA4, 8'hA4, 8'hA4, 8'hA4);

      // Load coincident with the boundary bypasses pending.
      chk("on_frame", 32'(frame_out), 32'h1);
      load(16'h0F00, 4'b0000, 4'b0000);
      chk("bypass_pending", 32'(pending_out), 32'h0);
      scan_frame(2, 8'hC0, 8'hC0, 8'h8E, Z);

      // Per-digit blanking; anodes keep scanning.
      step(3);
      load(16'h8888, 4'b0000, 4'b1010);
      wait_frame(cnt);
      scan_frame(1, 8'h80, 8'hFF, 8'h80, 8'hFF);

      // Leading-zero case.
      step(3);
      load(16'h0050, 4'b0000, 4'b0000);
      wait_frame(cnt);
      scan_frame(1, 8'hC0, 8'h92, Z, Z);

      // Reset in slot 2 with an update pending.
      step(3);
      load(16'h1234, 4'b0000, 4'b0000);
      step(16);
      chk("pre_rst_an", 32'(an_out), 32'hB);
      chk("pre_rst_pending", 32'(pending_out), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("async_sseg", 32'(sseg_out), 32'hFF);
      chk("async_an", 32'(an_out), 32'hF);
      chk("async_pending", 32'(pending_out), 32'h0);
      chk("async_frame", 32'(frame_out), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      wait_frame(cnt);
      chk("restart_frame_edges", 32'(cnt), 32'd31);
      chk("restart_pending", 32'(pending_out), 32'h0);
      scan_frame(1, 8'hC0, Z, Z, Z);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
